fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of the async FIFO (wdata/wen/full) among
//  N_REQ requesters in the write clock domain. Each requester offers words via valid/ready;
//  the arbiter grants one owner at a time, muxes its data onto wdata and never writes when full.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared state type and index helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  // Owner index width is $clog2(N_REQ); clamp to one bit so a degenerate N still elaborates.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req_i at start_i, start_i+1, ... with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  int cand;

  // Scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(start_i) + i;
      if (cand >= N) cand = cand - N;
      if (req_i[IDW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ valid/ready requesters.
// Define ARB_BURST_EN to hold a grant for up to MAX_BURST words; otherwise arbitration is per word.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                          wclk,
  input  logic                          wrstn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*WIDTH-1:0]        req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          full,
  output logic                          wen,
  output logic [WIDTH-1:0]              wdata,
  output logic [idx_width(N_REQ)-1:0]   owner,
  output logic                          busy
);

  localparam int IDW = idx_width(N_REQ);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] pick_start, pick_idx;
  logic           pick_found;
  logic           owner_valid;
  logic           burst_end;
  logic           release_grant;

  assign owner_valid   = req_valid[owner_q];
  assign wen           = (state_q == GRANT) & owner_valid & ~full;
  assign release_grant = (state_q == GRANT) & ((wen & burst_end) | ~owner_valid);

  // On release last becomes owner, so both states search from one past the latest grant.
  assign pick_start = (state_q == GRANT) ? IDW'(rr_next(int'(owner_q), N_REQ))
                                         : IDW'(rr_next(int'(last_q), N_REQ));

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .req_i   (req_valid),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = wen;
  end

  assign wdata = wen ? req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d = GRANT;
        owner_d = pick_idx;
      end
    end else if (release_grant) begin
      last_d = owner_q;
      if (pick_found) owner_d = pick_idx;
      else            state_d = IDLE;
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_BURST_EN
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

  assign burst_end = (burst_cnt_q == BCW'(MAX_BURST - 1));

  // Every new grant, including a back-to-back re-grant, starts counting from zero.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE || release_grant) burst_cnt_d = '0;
    else if (wen)                         burst_cnt_d = burst_cnt_q + 1'b1;
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end
`else
  assign burst_end = 1'b1;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a behavioural model.
// Builds for either setting of ARB_BURST_EN; the model's burst length follows the macro.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
`ifdef ARB_BURST_EN
  localparam int BL = MB;
`else
  localparam int BL = 1;
`endif

  logic           wclk;
  logic           wrstn;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           full;
  logic           wen;
  logic [W-1:0]   wdata;
  logic [1:0]     owner;
  logic           busy;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrstn     (wrstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wen       (wen),
    .wdata     (wdata),
    .owner     (owner),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;

  // Per-requester pending words: head is the word currently offered.
  logic [W-1:0] q [N][$];

  // Reference model state: who holds the grant and how many words it has moved.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_cnt;

  logic       obs_wen;
  logic [1:0] obs_owner;
  logic       obs_busy;
  int         written;
  int         pushed;

  function automatic int rr_first(input logic [N-1:0] v, input int from);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (from + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_cnt   = 0;
  endtask

  // One clock: present queue heads, check outputs against the model, then advance model and queues.
  task automatic run_cycle(input bit f);
    logic [N-1:0] v;
    logic         exp_wen;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] exp_wd;
    int           j;
    int           done;
    int           pop_idx;
    for (int i = 0; i < N; i++) begin
      v[i] = (q[i].size() > 0);
      req_data[i*W +: W] = v[i] ? q[i][0] : '0;
    end
    req_valid = v;
    full      = f;
    #2;
    exp_wen = m_busy && v[m_owner] && !f;
    exp_rdy = '0;
    if (exp_wen) exp_rdy[m_owner] = 1'b1;
    exp_wd  = exp_wen ? q[m_owner][0] : '0;
    pop_idx = m_owner;

    total++;
    if (wen !== exp_wen) begin
      bad++;
      $display("[TB] FAIL wen: got %b want %b at %0t", wen, exp_wen, $time);
    end
    total++;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("[TB] FAIL req_ready: got %b want %b at %0t", req_ready, exp_rdy, $time);
    end
    total++;
    if (wdata !== exp_wd) begin
      bad++;
      $display("[TB] FAIL wdata: got %h want %h at %0t", wdata, exp_wd, $time);
    end
    total++;
    if (owner !== 2'(m_owner)) begin
      bad++;
      $display("[TB] FAIL owner: got %0d want %0d at %0t", owner, m_owner, $time);
    end
    total++;
    if (busy !== m_busy) begin
      bad++;
      $display("[TB] FAIL busy: got %b want %b at %0t", busy, m_busy, $time);
    end
    total++;
    if ((wen & f) !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_while_full: got wen=%b with full=%b at %0t", wen, f, $time);
    end

    obs_wen   = wen;
    obs_owner = owner;
    obs_busy  = busy;
    if (wen === 1'b1) written++;

    if (wrstn) begin
      if (!m_busy) begin
        j = rr_first(v, (m_last + 1) % N);
        if (j >= 0) begin
          m_busy  = 1'b1;
          m_owner = j;
          m_cnt   = 0;
        end
      end else begin
        done = m_cnt + (exp_wen ? 1 : 0);
        if ((exp_wen && done >= BL) || !v[m_owner]) begin
          m_last = m_owner;
          j = rr_first(v, (m_owner + 1) % N);
          if (j >= 0) begin
            m_owner = j;
            m_cnt   = 0;
          end else begin
            m_busy = 1'b0;
          end
        end else begin
          m_cnt = done;
        end
      end
      if (exp_wen) void'(q[pop_idx].pop_front());
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    model_reset();
    wrstn = 1'b0;
    run_cycle(1'b0);
    wrstn = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    for (int i = 0; i < N; i++) q[i].delete();
    for (int i = 0; i < N; i++) q[i].push_back(W'($urandom));
    model_reset();
    wrstn = 1'b0;
    run_cycle(1'b0);
    run_cycle(1'b0);
    total++;
    if (req_ready !== '0 || wen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got wen=%b ready=%b want 0/0000", wen, req_ready);
    end
    wrstn = 1'b1;
    run_cycle(1'b0);
    run_cycle(1'b0);
    total++;
    if (obs_wen !== 1'b1 || obs_owner !== 2'd0) begin
      bad++;
      $display("[TB] FAIL first_grant: got wen=%b owner=%0d want 1/0", obs_wen, obs_owner);
    end
  endtask

  task automatic test_all_valid();
    int exp_seq [5];
`ifdef ARB_BURST_EN
    exp_seq = '{0, 0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    $display("[TB] test_all_valid");
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(W'($urandom));
    run_cycle(1'b0);
    total++;
    if (obs_wen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL all_valid_latency: got wen=%b want 0", obs_wen);
    end
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0);
      total++;
      if (obs_wen !== 1'b1 || obs_owner !== 2'(exp_seq[k])) begin
        bad++;
        $display("[TB] FAIL all_valid_order[%0d]: got wen=%b owner=%0d want 1/%0d", k, obs_wen, obs_owner, exp_seq[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_o;
    $display("[TB] test_back_to_back");
    do_reset();
    for (int k = 0; k < 8; k++) begin
      q[0].push_back(W'($urandom));
      q[2].push_back(W'($urandom));
    end
    run_cycle(1'b0);
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_BURST_EN
      exp_o = (k < 4) ? 0 : 2;
`else
      exp_o = (k % 2 == 0) ? 0 : 2;
`endif
      run_cycle(1'b0);
      total++;
      if (obs_wen !== 1'b1 || obs_owner !== 2'(exp_o)) begin
        bad++;
        $display("[TB] FAIL two_req_order[%0d]: got wen=%b owner=%0d want 1/%0d", k, obs_wen, obs_owner, exp_o);
      end
    end
  endtask

  task automatic test_full_stall();
    $display("[TB] test_full_stall");
    do_reset();
    for (int k = 0; k < 6; k++) q[1].push_back(W'($urandom));
    run_cycle(1'b0);
    run_cycle(1'b0);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1);
      total++;
      if (obs_wen !== 1'b0 || obs_owner !== 2'd1 || obs_busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL full_stall[%0d]: got wen=%b owner=%0d busy=%b want 0/1/1", k, obs_wen, obs_owner, obs_busy);
      end
    end
    run_cycle(1'b0);
    total++;
    if (obs_wen !== 1'b1 || obs_owner !== 2'd1) begin
      bad++;
      $display("[TB] FAIL full_resume: got wen=%b owner=%0d want 1/1", obs_wen, obs_owner);
    end
  endtask

  task automatic test_sole_requester();
    int writes;
    bit idle_seen;
    $display("[TB] test_sole_requester");
    do_reset();
    for (int k = 0; k < 6; k++) q[3].push_back(W'($urandom));
    run_cycle(1'b0);
    writes = 0;
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b0);
      if (obs_wen === 1'b1 && obs_owner === 2'd3) writes++;
    end
    total++;
    if (writes != 6) begin
      bad++;
      $display("[TB] FAIL sole_writes: got %0d back-to-back want 6", writes);
    end
    idle_seen = 1'b0;
    for (int k = 0; k < 5 && !idle_seen; k++) begin
      run_cycle(1'b0);
      if (obs_busy === 1'b0) idle_seen = 1'b1;
    end
    total++;
    if (!idle_seen) begin
      bad++;
      $display("[TB] FAIL sole_idle: got busy=%b want 0 within 5 cycles", obs_busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int left;
    $display("[TB] test_reset_mid_burst");
    do_reset();
    for (int k = 0; k < 8; k++) q[2].push_back(W'($urandom));
    run_cycle(1'b0);
    run_cycle(1'b0);
    run_cycle(1'b0);
    left = q[2].size();
    wrstn = 1'b0;
    #2;
    total++;
    if (wen !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || wdata !== '0 || owner !== 2'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got wen=%b ready=%b busy=%b wdata=%h owner=%0d want all 0",
               wen, req_ready, busy, wdata, owner);
    end
    model_reset();
    q[0].push_back(W'($urandom));
    q[0].push_back(W'($urandom));
    @(posedge wclk);
    #1;
    run_cycle(1'b0);
    wrstn = 1'b1;
    total++;
    if (q[2].size() != left) begin
      bad++;
      $display("[TB] FAIL inflight_kept: got %0d words left want %0d", q[2].size(), left);
    end
    run_cycle(1'b0);
    run_cycle(1'b0);
    total++;
    if (obs_wen !== 1'b1 || obs_owner !== 2'd0) begin
      bad++;
      $display("[TB] FAIL post_reset_grant: got wen=%b owner=%0d want 1/0", obs_wen, obs_owner);
    end
  endtask

  task automatic test_random();
    bit pending;
    $display("[TB] test_random");
    do_reset();
    written = 0;
    pushed  = 0;
    for (int c = 0; c < 400; c++) begin
      run_cycle($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0 && q[i].size() < 6) begin
          q[i].push_back(W'($urandom));
          pushed++;
        end
      end
    end
    pending = 1'b1;
    for (int c = 0; c < 300 && pending; c++) begin
      run_cycle(1'b0);
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1'b1;
    end
    total++;
    if (pending) begin
      bad++;
      $display("[TB] FAIL drain: got words still queued want none after 300 cycles");
    end
    total++;
    if (written != pushed) begin
      bad++;
      $display("[TB] FAIL word_count: got %0d writes want %0d", written, pushed);
    end
  endtask

  initial begin
    wrstn     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    written   = 0;
    pushed    = 0;
    model_reset();
    @(posedge wclk);
    #1;
    test_reset();
    test_all_valid();
    test_back_to_back();
    test_full_stall();
    test_sole_requester();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
